// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO frame reader.
// Read states, in-flight tags and header size.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    HDR_HI,
    HDR_LO,
    PAYLOAD
  } state_e;

  typedef enum logic [1:0] {
    TAG_HDR,
    TAG_PAY,
    TAG_PAY_LAST
  } tag_e;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer of {last, data}.
// Head entry drives the output; occupancy exported for flow control.
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_last,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         rd_last,
  output logic [1:0]   occ
);

  logic [W:0] e0_q, e0_d;
  logic [W:0] e1_q, e1_d;
  logic [1:0] occ_q, occ_d;
  logic       pop;
  logic [1:0] lvl;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    pop   = rd_ready && (occ_q != 2'd0);
    lvl   = occ_q;
    if (pop) begin
      e0_d = e1_q;
      lvl  = occ_q - 2'd1;
    end
    occ_d = lvl;
    if (wr_en) begin
      unique case (1'b1)
        (lvl == 2'd0): e0_d = {wr_last, wr_data};
        (lvl == 2'd1): e1_d = {wr_last, wr_data};
        default: ;
      endcase
      if (lvl != 2'd2) occ_d = lvl + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = e0_q[W-1:0];
  assign rd_last  = e0_q[W];
  assign occ      = occ_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains length-prefixed frames from the CDC FIFO read port
// and streams the payload as valid/ready bytes with a last flag.
module fifo_frame_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rd_srstn,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             len_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int HDR_W = HDR_BYTES * WIDTH;

  state_e           state_q, state_d;
  logic             rd_vld_q, rd_vld_d;
  tag_e             rd_tag_q, rd_tag_d;
  logic [WIDTH-1:0] len_hi_q, len_hi_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  logic             hdr_inflt;
  logic [HDR_W-1:0] len_full;
  logic             issue;
  tag_e             tag;
  logic             pop;
  logic [2:0]       lvl;
  logic [1:0]       occ;
  logic             buf_wr;
  logic             buf_last;

  assign pop       = m_valid && m_ready;
  assign hdr_inflt = rd_vld_q && (rd_tag_q == TAG_HDR);
  assign len_full  = {len_hi_q, fifo_rd_data};
  assign buf_wr    = rd_vld_q && (rd_tag_q != TAG_HDR);
  assign buf_last  = (rd_tag_q == TAG_PAY_LAST);

  // A byte popped this cycle frees its slot before the new read lands.
  assign lvl = {1'b0, occ} + {2'b00, rd_vld_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    rem_d     = rem_q;
    len_err_d = 1'b0;
    issue     = 1'b0;
    tag       = TAG_HDR;
    cnt_d     = cnt_q;
    unique case (state_q)
      HDR_HI: begin
        issue = !fifo_empty && !hdr_inflt;
        if (hdr_inflt) begin
          len_hi_d = fifo_rd_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        issue = !fifo_empty && !hdr_inflt;
        if (hdr_inflt) begin
          if ((len_full != '0) &&
              (len_full <= HDR_W'(MAX_LEN))) begin
            rem_d   = LEN_W'(len_full);
            state_d = PAYLOAD;
          end else begin
            len_err_d = 1'b1;
            state_d   = HDR_HI;
          end
        end
      end
      PAYLOAD: begin
        issue = !fifo_empty && (rem_q != '0) &&
                (lvl < 3'd2);
        tag   = (rem_q == LEN_W'(1)) ? TAG_PAY_LAST
                                      : TAG_PAY;
        if (issue) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase
    if (pop && m_last) cnt_d = cnt_q + CNT_W'(1);
  end

  assign fifo_rd_en = issue && rd_srstn;
  assign rd_vld_d   = fifo_rd_en;
  assign rd_tag_d   = tag;

  always_ff @(posedge rclk) begin
    if (!rd_srstn) begin
      state_q   <= HDR_HI;
      rd_vld_q  <= 1'b0;
      rd_tag_q  <= TAG_HDR;
      len_hi_q  <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= rd_vld_d;
      rd_tag_q  <= rd_tag_d;
      len_hi_q  <= len_hi_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  skid_buf2 #(
    .W(WIDTH)
  ) u_skid (
    .clk      (rclk),
    .srstn    (rd_srstn),
    .wr_en    (buf_wr),
    .wr_data  (fifo_rd_data),
    .wr_last  (buf_last),
    .rd_ready (m_ready),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .rd_last  (m_last),
    .occ      (occ)
  );

  assign len_err   = len_err_q;
  assign frame_cnt = cnt_q;
  assign busy      = !((state_q == HDR_HI) &&
                       (occ == 2'd0) && !rd_vld_q);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader.
// A FIFO model feeds frames; a monitor checks every accepted byte.
module tb_fifo_frame_reader;
  import fifo_rd_pkg::*;

  logic        rclk = 1'b0;
  logic        rd_srstn;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        len_err;
  logic [15:0] frame_cnt;
  logic        busy;

  always #5 rclk = ~rclk;

  fifo_frame_reader u_dut (
    .rclk         (rclk),
    .rd_srstn     (rd_srstn),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .len_err      (len_err),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  logic [7:0]  fmem [4096];
  logic [11:0] wr_ptr = '0;
  logic [11:0] rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (!rd_srstn) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 12'd1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, got, exp);
  endtask

  logic [8:0] exp_mem [4096];
  int exp_wr = 0;
  int exp_rd = 0;
  int pop_cyc [4096];
  int rd_cyc [8192];
  int rd_n   = 0;
  int last_n = 0;
  int lerr_n = 0;
  int cyc    = 0;

  logic       stall_q = 1'b0;
  logic [8:0] prev_q  = '0;

  always @(negedge rclk) begin
    cyc++;
    if (!rd_srstn) begin
      stall_q = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_while_empty", int'(fifo_empty), 0);
        rd_cyc[rd_n] = cyc;
        rd_n++;
      end
      if (stall_q)
        check("hold_stable", int'({m_valid, m_last, m_data}),
              int'({1'b1, prev_q}));
      if (m_valid && m_ready) begin
        if (exp_rd == exp_wr) begin
          check("unexpected_byte", int'({m_last, m_data}), -1);
        end else begin
          check("byte", int'({m_last, m_data}),
                int'(exp_mem[exp_rd]));
          pop_cyc[exp_rd] = cyc;
          exp_rd++;
        end
        if (m_last) last_n++;
      end
      if (len_err) lerr_n++;
      stall_q = m_valid && !m_ready;
      prev_q  = {m_last, m_data};
    end
  end

  logic   hold = 1'b0;
  logic   rmode = 1'b0;
  logic [3:0] pat = 4'b1001;

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge rclk);
      #3;
      if (hold) m_ready = 1'b0;
      else if (rmode) m_ready = pat[3 - (k % 4)];
      else m_ready = 1'b1;
      k++;
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr = wr_ptr + 12'd1;
  endtask

  task automatic expect_b(input logic [7:0] d,
                          input logic l);
    exp_mem[exp_wr] = {l, d};
    exp_wr++;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge rclk);
      #2;
      if (exp_rd == exp_wr && !busy && fifo_empty &&
          !fifo_rd_en) done = 1'b1;
    end
    check({nm, "_timeout"}, int'(done), 1);
    repeat (3) @(posedge rclk);
    #2;
  endtask

  int br, be, bl, bm;

  initial begin
    rd_srstn = 1'b0;
    repeat (3) @(posedge rclk);
    #2;
    check("rst_valid", int'(m_valid), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_len_err", int'(len_err), 0);
    check("rst_cnt", int'(frame_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    rd_srstn = 1'b1;
    @(posedge rclk);
    #2;

    br = rd_n; be = exp_wr; bl = lerr_n;
    push(8'h00); push(8'h03);
    push(8'hA1); push(8'hA2); push(8'hA3);
    expect_b(8'hA1, 0); expect_b(8'hA2, 0);
    expect_b(8'hA3, 1);
    wait_idle("f3");
    check("f3_reads", rd_n - br, 5);
    check("f3_cnt", int'(frame_cnt), 1);
    check("f3_latency", pop_cyc[be] - rd_cyc[br], 6);
    check("f3_stream", pop_cyc[be + 2] - pop_cyc[be], 2);
    check("f3_len_err", lerr_n - bl, 0);

    br = rd_n;
    rmode = 1'b1;
    push(8'h00); push(8'h03);
    push(8'hA1); push(8'hA2); push(8'hA3);
    expect_b(8'hA1, 0); expect_b(8'hA2, 0);
    expect_b(8'hA3, 1);
    wait_idle("stall");
    rmode = 1'b0;
    check("stall_reads", rd_n - br, 5);
    check("stall_cnt", int'(frame_cnt), 2);

    br = rd_n; bl = lerr_n;
    push(8'h00); push(8'h00);
    push(8'h00); push(8'h01); push(8'h5A);
    expect_b(8'h5A, 1);
    wait_idle("zero");
    check("zero_len_err", lerr_n - bl, 1);
    check("zero_cnt", int'(frame_cnt), 3);
    check("zero_reads", rd_n - br, 5);

    br = rd_n; bl = lerr_n;
    push(8'h05); push(8'hEF);
    wait_idle("big");
    check("big_len_err", lerr_n - bl, 1);
    check("big_cnt", int'(frame_cnt), 3);
    check("big_reads", rd_n - br, 2);
    check("big_state", int'(u_dut.state_q), int'(HDR_HI));
    check("big_busy", int'(busy), 0);

    bl = lerr_n; bm = last_n;
    push(8'h05); push(8'hEE);
    for (int i = 0; i < 1518; i++) begin
      push(8'(i));
      expect_b(8'(i), i == 1517);
    end
    wait_idle("max");
    check("max_len_err", lerr_n - bl, 0);
    check("max_cnt", int'(frame_cnt), 4);
    check("max_last", last_n - bm, 1);

    br = rd_n; be = exp_wr; bm = last_n;
    push(8'h00); push(8'h01); push(8'hB1);
    push(8'h00); push(8'h02); push(8'hC1); push(8'hC2);
    expect_b(8'hB1, 1);
    expect_b(8'hC1, 0); expect_b(8'hC2, 1);
    wait_idle("b2b");
    check("b2b_overlap", pop_cyc[be + 2] - rd_cyc[br], 12);
    check("b2b_cnt", int'(frame_cnt), 6);
    check("b2b_last", last_n - bm, 2);
    check("b2b_reads", rd_n - br, 7);

    be = exp_wr;
    push(8'h00); push(8'h04);
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    expect_b(8'hD1, 0); expect_b(8'hD2, 0);
    begin
      bit got2;
      got2 = 1'b0;
      for (int i = 0; i < 200 && !got2; i++) begin
        @(posedge rclk);
        #2;
        if (exp_rd == be + 2) got2 = 1'b1;
      end
      check("rst_mid_reached", int'(got2), 1);
    end
    hold = 1'b1;
    rd_srstn = 1'b0;
    @(posedge rclk);
    #2;
    check("mid_rst_valid", int'(m_valid), 0);
    check("mid_rst_cnt", int'(frame_cnt), 0);
    check("mid_rst_state", int'(u_dut.state_q), int'(HDR_HI));
    rd_srstn = 1'b1;
    hold = 1'b0;
    @(posedge rclk);
    #2;
    push(8'h00); push(8'h01); push(8'h77);
    expect_b(8'h77, 1);
    wait_idle("post_rst");
    check("post_rst_cnt", int'(frame_cnt), 1);
    check("post_rst_drained", exp_rd, exp_wr);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
